out_port_arb: RTL and testbench
===============================

# out_port_arb

Per-output-port switch allocator for the Cardinal router. One instance sits behind each of the five output ports (N, S, E, W, PE) and takes that port's 5-bit request vectors from the two per-VC request matrices. Each cycle it chooses at most one input for the VC being served, using round-robin priority. It drives the crossbar select, the input-buffer pops and the output-buffer write, and keeps per-VC fairness pointers and saturating grant counters.

## Interface

Parameters:
- PTR_RESET, 0: reset value of both round-robin pointers (0..4).
- CNT_W, 16: width of each grant counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- polarity  in  1  VC served this cycle: 0 → VC0, 1 → VC1.
- req_vc0  in  5  VC0 requests to this output. Bit order {N,S,E,W,PE} maps to bits {4,3,2,1,0}.
- req_vc1  in  5  VC1 requests, same bit order.
- out_full_vc0  in  1  this port's VC0 output buffer is full.
- out_full_vc1  in  1  this port's VC1 output buffer is full.
- grant  out  5  one-hot crossbar select, same bit order. All zero when idle.
- in_re  out  5  pop strobes to the input buffers of the served VC. Equal to grant.
- out_we  out  1  write strobe to the output buffer of the served VC.
- out_vc  out  1  VC of the current transfer. Equal to polarity.
- grant_cnt_vc0  out  CNT_W  saturating count of VC0 grants.
- grant_cnt_vc1  out  CNT_W  saturating count of VC1 grants.

## Operation

- Served VC: v = polarity. Served request vector: r = v ? req_vc1 : req_vc0. Served full flag: f = v ? out_full_vc1 : out_full_vc0.
- The other VC's requests and full flag have no effect this cycle, and its pointer and counter hold.
- Eligible condition: r != 0 and f == 0.
- When eligible, grant is the one-hot bit of the first set bit of r. The search starts at index ptr_v and increases, wrapping 4→0.
- When not eligible, grant = 0 and out_we = 0.
- in_re = grant. out_we = |grant. out_vc = v.
- Pointer update, clocked:
  - on a grant to index i, ptr_v ← (i == 4) ? 0 : i+1;
  - with no grant, ptr_v holds;
  - ptr values 5..7 are unreachable; if one occurs, treat it as 0.
- Counter update, clocked: on a grant, grant_cnt_v ← grant_cnt_v + 1, saturating at 2^CNT_W−1. With no grant it holds.
- A single input requesting continuously is granted on every cycle its VC is served. Fairness applies only among simultaneous requesters.
- Two inputs requesting the same output on the same VC are granted alternately on successive served cycles of that VC.
- The block is stateless apart from ptr_vc0, ptr_vc1, grant_cnt_vc0 and grant_cnt_vc1.

## Timing

- Reset, sampled at a rising edge while reset = 1:
  - ptr_vc0 = ptr_vc1 = PTR_RESET;
  - both counters = 0.
- While reset = 1, grant, in_re and out_we are forced to 0. No pop or write may escape during reset.
- grant, in_re, out_we and out_vc are combinational from the current-cycle inputs and registered state. Decision latency is 0 cycles, so the pop and the write occur on the same edge as the decision.
- The pointer and counter take their new values at the same edge as the transfer. They are visible in the next cycle.
- Simultaneous grant and out_full rising: the full flag is sampled in the current cycle only. If f = 0 now, the grant stands.
- Request withdrawn in the same cycle: r is not latched, so the result is no grant and no pointer movement.
- Reset asserted mid-stream: any transfer in that cycle is suppressed. State returns to reset values at that edge, with no partial update.
- Polarity toggling every cycle is the normal mode: VC0 and VC1 decisions interleave, each with its own pointer.

## Test plan

- **Reset:** assert reset for 2 cycles with req_vc0 = 5'b11111 and polarity = 0.
  - During reset: grant = 0, out_we = 0.
  - After release, first cycle: grant = 5'b00001 (PE).
  - grant_cnt_vc0 = 1 on the next cycle.
- **Round-robin, single VC:** polarity = 0, req_vc0 = 5'b10101 held for 6 cycles, out_full_vc0 = 0.
  - Grants: 00001, 00100, 10000, 00001, 00100, 10000.
  - ptr_vc0 after each: 1, 3, 0, 1, 3, 0.
- **Backpressure:** polarity = 0, req_vc0 = 5'b01000, out_full_vc0 = 1 for 3 cycles, then 0.
  - grant = 0 for the 3 full cycles, then 01000.
  - Counter and pointer are unchanged until the grant.
- **VC interleave:** polarity toggles every cycle, starting at 0; req_vc0 = 5'b00011, req_vc1 = 5'b11000.
  - Even cycles: 00001, 00010, 00001, …
  - Odd cycles: 01000, 10000, 01000, …
  - out_vc tracks polarity.
- **Counter saturation:** CNT_W = 4, 20 consecutive VC1 grants.
  - grant_cnt_vc1 stops at 15.
  - grant_cnt_vc0 stays 0.
- **Reset mid-stream:** during the round-robin test, after the grant to index 2 (ptr_vc0 = 3), assert reset for 1 cycle.
  - That cycle: out_we = 0.
  - Next cycle: grant = 00001 (pointer back to 0).

Source files
------------

// File: rtl/out_port_arb_if.sv
// out_port_arb_if: request/grant bundle between the router core and one output-port allocator.
//   master: drives polarity, per-VC request vectors and output-full flags; observes grants and counters.
//   slave : the allocator; consumes requests, drives grant, in_re, out_we, out_vc and grant counters.
interface out_port_arb_if #(parameter int CNT_W = 16);
  logic             polarity;
  logic [4:0]       req_vc0;
  logic [4:0]       req_vc1;
  logic             out_full_vc0;
  logic             out_full_vc1;
  logic [4:0]       grant;
  logic [4:0]       in_re;
  logic             out_we;
  logic             out_vc;
  logic [CNT_W-1:0] grant_cnt_vc0;
  logic [CNT_W-1:0] grant_cnt_vc1;
  modport master (
    output polarity, req_vc0, req_vc1, out_full_vc0, out_full_vc1,
    input  grant, in_re, out_we, out_vc, grant_cnt_vc0, grant_cnt_vc1
  );
  modport slave (
    input  polarity, req_vc0, req_vc1, out_full_vc0, out_full_vc1,
    output grant, in_re, out_we, out_vc, grant_cnt_vc0, grant_cnt_vc1
  );
endinterface

// File: rtl/out_port_arb.sv
// out_port_arb: per-output-port round-robin switch allocator with per-VC pointers and saturating grant counters.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; also masks grant/in_re/out_we in the same cycle
//   bus   : slave side of out_port_arb_if (polarity selects the served VC; bit order {N,S,E,W,PE} = {4..0})
module out_port_arb #(
  parameter int PTR_RESET = 0,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          reset,
  out_port_arb_if.slave bus
);
  logic [2:0]       ptr_vc0_q, ptr_vc0_d, ptr_vc1_q, ptr_vc1_d;
  logic [CNT_W-1:0] cnt_vc0_q, cnt_vc0_d, cnt_vc1_q, cnt_vc1_d;
  logic             v, f, hit, go;
  logic [4:0]       r, gnt;
  logic [2:0]       p_raw, p, idx, nxt;
  logic [3:0]       c;
  always_comb begin
    v     = bus.polarity;
    r     = v ? bus.req_vc1 : bus.req_vc0;
    f     = v ? bus.out_full_vc1 : bus.out_full_vc0;
    p_raw = v ? ptr_vc1_q : ptr_vc0_q;
    // pointer codes 5..7 cannot arise normally; fold them onto 0 so the search stays in range
    p     = (p_raw > 3'd4) ? 3'd0 : p_raw;
    hit   = 1'b0;
    idx   = 3'd0;
    c     = 4'd0;
    // scan the five inputs starting at the pointer, wrapping 4 -> 0; first requester wins
    for (int k = 0; k < 5; k++) begin
      c = {1'b0, p} + 4'(k);
      c = (c > 4'd4) ? c - 4'd5 : c;
      if (!hit && r[c[2:0]]) begin
        hit = 1'b1;
        idx = c[2:0];
      end
    end
    go        = hit && !f && !reset;
    gnt       = go ? (5'b00001 << idx) : 5'b00000;
    nxt       = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    ptr_vc0_d = (go && !v) ? nxt : ptr_vc0_q;
    ptr_vc1_d = (go &&  v) ? nxt : ptr_vc1_q;
    cnt_vc0_d = (go && !v && cnt_vc0_q != '1) ? cnt_vc0_q + 1'b1 : cnt_vc0_q;
    cnt_vc1_d = (go &&  v && cnt_vc1_q != '1) ? cnt_vc1_q + 1'b1 : cnt_vc1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_vc0_q <= 3'(PTR_RESET);
      ptr_vc1_q <= 3'(PTR_RESET);
      cnt_vc0_q <= '0;
      cnt_vc1_q <= '0;
    end else begin
      ptr_vc0_q <= ptr_vc0_d;
      ptr_vc1_q <= ptr_vc1_d;
      cnt_vc0_q <= cnt_vc0_d;
      cnt_vc1_q <= cnt_vc1_d;
    end
  end
  assign bus.grant         = gnt;
  assign bus.in_re         = gnt;
  assign bus.out_we        = |gnt;
  assign bus.out_vc        = v;
  assign bus.grant_cnt_vc0 = cnt_vc0_q;
  assign bus.grant_cnt_vc1 = cnt_vc1_q;
endmodule

// File: tb/tb_out_port_arb.sv
// tb_out_port_arb: scoreboard bench for out_port_arb against a behavioural round-robin model.
module tb_out_port_arb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  out_port_arb_if #(.CNT_W(4)) bus();
  out_port_arb #(.PTR_RESET(0), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [4:0] g;
    logic       vc;
    int         c0;
    int         c1;
    int         plan;
    string      tag;
  } exp_t;
  exp_t q[$];
  int mptr[2];
  int mcnt[2];
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step(input bit rst, input bit pol, input logic [4:0] r0, input logic [4:0] r1,
                      input bit f0, input bit f1, input int plan, input string tag);
    exp_t e;
    int v;
    int idx;
    logic [4:0] r;
    reset = rst;
    bus.polarity = pol;
    bus.req_vc0 = r0;
    bus.req_vc1 = r1;
    bus.out_full_vc0 = f0;
    bus.out_full_vc1 = f1;
    v = int'(pol);
    r = pol ? r1 : r0;
    idx = -1;
    if (!rst && !(pol ? f1 : f0))
      for (int k = 0; k < 5; k++)
        if (idx < 0 && r[(mptr[v] + k) % 5]) idx = (mptr[v] + k) % 5;
    e.g = (idx >= 0) ? 5'(1 << idx) : 5'b0;
    e.vc = pol;
    e.c0 = mcnt[0];
    e.c1 = mcnt[1];
    e.plan = plan;
    e.tag = tag;
    q.push_back(e);
    if (rst) begin
      mptr = '{0, 0};
      mcnt = '{0, 0};
    end else if (idx >= 0) begin
      mptr[v] = (idx + 1) % 5;
      mcnt[v] = (mcnt[v] == 15) ? 15 : mcnt[v] + 1;
    end
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, " grant"}, int'(bus.grant), int'(e.g));
      chk({e.tag, " in_re"}, int'(bus.in_re), int'(e.g));
      chk({e.tag, " out_we"}, int'(bus.out_we), int'(|e.g));
      chk({e.tag, " out_vc"}, int'(bus.out_vc), int'(e.vc));
      chk({e.tag, " cnt_vc0"}, int'(bus.grant_cnt_vc0), e.c0);
      chk({e.tag, " cnt_vc1"}, int'(bus.grant_cnt_vc1), e.c1);
      if (e.plan >= 0) chk({e.tag, " plan_grant"}, int'(bus.grant), e.plan);
    end
  end
  initial begin
    reset = 1'b1;
    bus.polarity = 1'b0;
    bus.req_vc0 = 5'b11111;
    bus.req_vc1 = 5'b0;
    bus.out_full_vc0 = 1'b0;
    bus.out_full_vc1 = 1'b0;
    mptr = '{0, 0};
    mcnt = '{0, 0};
    @(posedge clk);
    #1;
    step(1, 0, 5'b11111, 5'b0, 0, 0, 0, "reset0");
    step(1, 0, 5'b11111, 5'b0, 0, 0, 0, "reset1");
    step(0, 0, 5'b11111, 5'b0, 0, 0, 5'b00001, "post_reset");
    step(0, 0, 5'b00000, 5'b0, 0, 0, 0, "post_reset_cnt");
    step(1, 0, 5'b00000, 5'b0, 0, 0, 0, "rr_reset");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b00001, "rr0");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b00100, "rr1");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b10000, "rr2");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b00001, "rr3");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b00100, "rr4");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b10000, "rr5");
    step(1, 0, 5'b00000, 5'b0, 0, 0, 0, "mid_pre_reset");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b00001, "mid0");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b00100, "mid1");
    step(1, 0, 5'b10101, 5'b0, 0, 0, 0, "mid_reset");
    step(0, 0, 5'b10101, 5'b0, 0, 0, 5'b00001, "mid_after");
    step(0, 0, 5'b01000, 5'b0, 1, 0, 0, "bp_full0");
    step(0, 0, 5'b01000, 5'b0, 1, 0, 0, "bp_full1");
    step(0, 0, 5'b01000, 5'b0, 1, 0, 0, "bp_full2");
    step(0, 0, 5'b01000, 5'b0, 0, 0, 5'b01000, "bp_go");
    step(0, 0, 5'b00000, 5'b0, 0, 0, 0, "bp_cnt");
    step(1, 0, 5'b00000, 5'b0, 0, 0, 0, "il_reset");
    step(0, 0, 5'b00011, 5'b11000, 0, 0, 5'b00001, "il0");
    step(0, 1, 5'b00011, 5'b11000, 0, 0, 5'b01000, "il1");
    step(0, 0, 5'b00011, 5'b11000, 0, 0, 5'b00010, "il2");
    step(0, 1, 5'b00011, 5'b11000, 0, 0, 5'b10000, "il3");
    step(0, 0, 5'b00011, 5'b11000, 0, 0, 5'b00001, "il4");
    step(0, 1, 5'b00011, 5'b11000, 0, 0, 5'b01000, "il5");
    step(1, 0, 5'b00000, 5'b0, 0, 0, 0, "sat_reset");
    for (int i = 0; i < 20; i++)
      step(0, 1, 5'($urandom), 5'($urandom_range(1, 31)), 1'($urandom), 0, -1, "sat");
    step(0, 0, 5'b00000, 5'b0, 0, 0, 0, "sat_final");
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 39) == 0, 1'($urandom), 5'($urandom), 5'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, -1, "rand");
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
